// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM response stage
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_H  = 3'd1,
        LD_W  = 3'd2,
        LD_D  = 3'd3,
        LD_BU = 3'd4,
        LD_HU = 3'd5,
        LD_WU = 3'd6
    } ld_op_e;

    localparam int EXC_W = 86;

    // Exception flags occupy the low bits of the bus; the rest is payload (bad address etc.)
    localparam int EXC_FLAG_LO = 0;
    localparam int EXC_FLAG_W  = 22;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load data shift and sign/zero extension
module load_align
    import mem_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = $clog2(DW / 8)
) (
    input  logic [DW-1:0] rdata,
    input  logic [AW-1:0] addr_lo,
    input  logic [2:0]    ld_op,
    output logic [DW-1:0] result
);

    logic [DW-1:0] shifted;
    logic [31:0]   word_src;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        // A 32-bit datapath always returns the whole word as delivered
        word_src = (DW == 32) ? rdata[31:0] : shifted[31:0];
        result   = rdata;
        case (ld_op_e'(ld_op))
            LD_B:    result = DW'($signed(shifted[7:0]));
            LD_BU:   result = DW'(shifted[7:0]);
            LD_H:    result = DW'($signed(shifted[15:0]));
            LD_HU:   result = DW'(shifted[15:0]);
            LD_W:    result = DW'($signed(word_src));
            LD_WU:   result = DW'(word_src);
            LD_D:    result = shifted;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - MEM pipeline stage waiting on variable-latency SRAM responses
module mem_resp_stage #(
    parameter int DW        = 32,
    parameter int EXC_W     = mem_stage_pkg::EXC_W,
    parameter int MAX_OUTST = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_mem_valid,
    output logic             mem_allowin,
    input  logic [31:0]      ex_pc,
    input  logic             ex_res_from_mem,
    input  logic             ex_req_issued,
    input  logic             ex_rf_we,
    input  logic [4:0]       ex_rf_waddr,
    input  logic [DW-1:0]    ex_alu_result,
    input  logic [2:0]       ex_ld_op,
    input  logic [EXC_W-1:0] ex_except,
    input  logic             data_sram_data_ok,
    input  logic [DW-1:0]    data_sram_rdata,
    input  logic             wb_allowin,
    input  logic             wb_flush,
    output logic             mem_wb_valid,
    output logic [31:0]      mem_pc,
    output logic             mem_rf_we,
    output logic [4:0]       mem_rf_waddr,
    output logic [DW-1:0]    mem_rf_wdata,
    output logic [EXC_W-1:0] mem_except,
    output logic             mem_exc,
    output logic             mem_ld_stall
);
    import mem_stage_pkg::*;

    localparam int AW = $clog2(DW / 8);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW:0] CNT_ONE = (CW + 1)'(1);
    localparam logic [CW:0] CNT_MAX = (CW + 1)'(MAX_OUTST);

    logic             mem_valid_q, mem_valid_d;
    logic             wait_q, wait_d;
    logic             buf_v_q, buf_v_d;
    logic [DW-1:0]    buf_data_q, buf_data_d;
    logic [CW-1:0]    discard_cnt_q, discard_cnt_d;
    logic [31:0]      pc_q;
    logic             res_from_mem_q;
    logic             rf_we_q;
    logic [4:0]       rf_waddr_q;
    logic [DW-1:0]    alu_q;
    logic [2:0]       ld_op_q;
    logic [EXC_W-1:0] except_q;

    logic          resp_live;
    logic          ready_go;
    logic          accept;
    logic          buf_capture;
    logic [CW:0]   cnt_wide;
    logic [DW-1:0] rdata_eff;
    logic [DW-1:0] ld_result;

    assign resp_live   = data_sram_data_ok & (discard_cnt_q == '0);
    assign ready_go    = ~wait_q | buf_v_q | resp_live;
    assign mem_allowin = ~mem_valid_q | (ready_go & wb_allowin);
    assign accept      = ex_mem_valid & mem_allowin & ~wb_flush;
    // Response arrived but WB is blocked: park it so the SRAM bus is free to move on
    assign buf_capture = mem_valid_q & wait_q & ~buf_v_q & resp_live & ~wb_allowin;

    always_comb begin
        mem_valid_d = mem_valid_q;
        if (wb_flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = ex_mem_valid;
        end

        wait_d = accept ? ex_req_issued : wait_q;

        buf_v_d = buf_v_q;
        if (wb_flush || mem_allowin) begin
            buf_v_d = 1'b0;
        end else if (buf_capture) begin
            buf_v_d = 1'b1;
        end
        buf_data_d = buf_capture ? data_sram_rdata : buf_data_q;

        // Every response still owed to a killed instruction must be swallowed later
        cnt_wide = {1'b0, discard_cnt_q};
        if (wb_flush) begin
            if (mem_valid_q & wait_q & ~buf_v_q & ~resp_live) begin
                cnt_wide = cnt_wide + CNT_ONE;
            end
            if (ex_mem_valid & ex_req_issued) begin
                cnt_wide = cnt_wide + CNT_ONE;
            end
        end
        if (data_sram_data_ok && discard_cnt_q != '0) begin
            cnt_wide = cnt_wide - CNT_ONE;
        end
        discard_cnt_d = cnt_wide[CW-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q    <= 1'b0;
            wait_q         <= 1'b0;
            buf_v_q        <= 1'b0;
            buf_data_q     <= '0;
            discard_cnt_q  <= '0;
            pc_q           <= '0;
            res_from_mem_q <= 1'b0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            alu_q          <= '0;
            ld_op_q        <= '0;
            except_q       <= '0;
        end else begin
            mem_valid_q   <= mem_valid_d;
            wait_q        <= wait_d;
            buf_v_q       <= buf_v_d;
            buf_data_q    <= buf_data_d;
            discard_cnt_q <= discard_cnt_d;
            if (accept) begin
                pc_q           <= ex_pc;
                res_from_mem_q <= ex_res_from_mem;
                rf_we_q        <= ex_rf_we;
                rf_waddr_q     <= ex_rf_waddr;
                alu_q          <= ex_alu_result;
                ld_op_q        <= ex_ld_op;
                except_q       <= ex_except;
            end
        end
    end

    assign rdata_eff = buf_v_q ? buf_data_q : data_sram_rdata;

    load_align #(.DW(DW), .AW(AW)) u_load_align (
        .rdata   (rdata_eff),
        .addr_lo (alu_q[AW-1:0]),
        .ld_op   (ld_op_q),
        .result  (ld_result)
    );

    assign mem_wb_valid = mem_valid_q & ready_go;
    assign mem_pc       = pc_q;
    assign mem_rf_we    = rf_we_q & mem_valid_q;
    assign mem_rf_waddr = rf_waddr_q;
    assign mem_rf_wdata = res_from_mem_q ? ld_result : alu_q;
    assign mem_except   = except_q;
    assign mem_exc      = mem_valid_q & (|except_q[EXC_FLAG_LO +: EXC_FLAG_W]);
    assign mem_ld_stall = mem_valid_q & res_from_mem_q & ~ready_go;

    a_discard_bound: assert property (@(posedge clk) disable iff (!resetn) cnt_wide <= CNT_MAX);

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb/tb_mem_resp_stage.sv - scoreboard bench for mem_resp_stage at DW=32 and DW=64
module tb_mem_resp_stage;

    localparam int EXC_W = 86;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic             ex_mem_valid, ex_mem_valid64;
    logic [31:0]      ex_pc;
    logic             ex_res_from_mem, ex_req_issued, ex_rf_we;
    logic [4:0]       ex_rf_waddr;
    logic [31:0]      ex_alu;
    logic [63:0]      ex_alu64;
    logic [2:0]       ex_ld_op;
    logic [EXC_W-1:0] ex_except;
    logic             data_ok, data_ok64;
    logic [31:0]      rdata;
    logic [63:0]      rdata64;
    logic             wb_allowin, wb_flush;

    logic             mem_allowin, mem_wb_valid, mem_rf_we, mem_exc, mem_ld_stall;
    logic [31:0]      mem_pc, mem_rf_wdata;
    logic [4:0]       mem_rf_waddr;
    logic [EXC_W-1:0] mem_except;

    logic             mem_allowin64, mem_wb_valid64, mem_rf_we64, mem_exc64, mem_ld_stall64;
    logic [31:0]      mem_pc64;
    logic [63:0]      mem_rf_wdata64;
    logic [4:0]       mem_rf_waddr64;
    logic [EXC_W-1:0] mem_except64;

    mem_resp_stage #(.DW(32), .EXC_W(EXC_W), .MAX_OUTST(2)) u32 (
        .clk(clk), .resetn(resetn), .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
        .ex_pc(ex_pc), .ex_res_from_mem(ex_res_from_mem), .ex_req_issued(ex_req_issued),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_alu_result(ex_alu),
        .ex_ld_op(ex_ld_op), .ex_except(ex_except), .data_sram_data_ok(data_ok),
        .data_sram_rdata(rdata), .wb_allowin(wb_allowin), .wb_flush(wb_flush),
        .mem_wb_valid(mem_wb_valid), .mem_pc(mem_pc), .mem_rf_we(mem_rf_we),
        .mem_rf_waddr(mem_rf_waddr), .mem_rf_wdata(mem_rf_wdata), .mem_except(mem_except),
        .mem_exc(mem_exc), .mem_ld_stall(mem_ld_stall)
    );

    mem_resp_stage #(.DW(64), .EXC_W(EXC_W), .MAX_OUTST(2)) u64 (
        .clk(clk), .resetn(resetn), .ex_mem_valid(ex_mem_valid64), .mem_allowin(mem_allowin64),
        .ex_pc(ex_pc), .ex_res_from_mem(ex_res_from_mem), .ex_req_issued(ex_req_issued),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_alu_result(ex_alu64),
        .ex_ld_op(ex_ld_op), .ex_except(ex_except), .data_sram_data_ok(data_ok64),
        .data_sram_rdata(rdata64), .wb_allowin(wb_allowin), .wb_flush(wb_flush),
        .mem_wb_valid(mem_wb_valid64), .mem_pc(mem_pc64), .mem_rf_we(mem_rf_we64),
        .mem_rf_waddr(mem_rf_waddr64), .mem_rf_wdata(mem_rf_wdata64), .mem_except(mem_except64),
        .mem_exc(mem_exc64), .mem_ld_stall(mem_ld_stall64)
    );

    int   vec = 0;
    int   errs = 0;
    exp_t q32[$];
    exp_t q64[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit w64, input logic [31:0] pc, input logic [2:0] op,
                         input logic [63:0] addr, input logic rfm, input logic we,
                         input logic [4:0] wa, input logic req, input bit push,
                         input logic [63:0] exp_wdata);
        exp_t e;
        int   n;
        ex_pc = pc; ex_ld_op = op; ex_res_from_mem = rfm; ex_rf_we = we;
        ex_rf_waddr = wa; ex_req_issued = req;
        if (w64) begin ex_alu64 = addr; ex_mem_valid64 = 1'b1; end
        else     begin ex_alu = addr[31:0]; ex_mem_valid = 1'b1; end
        n = 0;
        while (!(w64 ? mem_allowin64 : mem_allowin) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            vec++; errs++;
            $display("FAIL allowin_timeout: pc 0x%0h not accepted within 20 cycles, expected accept", pc);
        end
        if (push) begin
            e.pc = pc; e.we = we; e.waddr = wa; e.wdata = exp_wdata;
            if (w64) q64.push_back(e); else q32.push_back(e);
        end
        step();
        ex_mem_valid = 1'b0; ex_mem_valid64 = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resetn && !wb_flush && mem_wb_valid && wb_allowin) begin
            if (q32.size() == 0) begin
                vec++; errs++;
                $display("FAIL unexpected32: pc 0x%0h wdata 0x%0h handed off, expected nothing", mem_pc, mem_rf_wdata);
            end else begin
                e = q32.pop_front();
                check("pc32", 64'(mem_pc), 64'(e.pc));
                check("we32", 64'(mem_rf_we), 64'(e.we));
                check("waddr32", 64'(mem_rf_waddr), 64'(e.waddr));
                check("wdata32", 64'(mem_rf_wdata), e.wdata);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resetn && !wb_flush && mem_wb_valid64 && wb_allowin) begin
            if (q64.size() == 0) begin
                vec++; errs++;
                $display("FAIL unexpected64: pc 0x%0h wdata 0x%0h handed off, expected nothing", mem_pc64, mem_rf_wdata64);
            end else begin
                e = q64.pop_front();
                check("pc64", 64'(mem_pc64), 64'(e.pc));
                check("waddr64", 64'(mem_rf_waddr64), 64'(e.waddr));
                check("wdata64", mem_rf_wdata64, e.wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        ex_mem_valid = 0; ex_mem_valid64 = 0; ex_pc = 0; ex_res_from_mem = 0;
        ex_req_issued = 0; ex_rf_we = 0; ex_rf_waddr = 0; ex_alu = 0; ex_alu64 = 0;
        ex_ld_op = 0; ex_except = '0; data_ok = 0; data_ok64 = 0; rdata = 0; rdata64 = 0;
        wb_allowin = 1; wb_flush = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wb_valid", 64'(mem_wb_valid), 0);
        check("rst_pc", 64'(mem_pc), 0);
        check("rst_wdata", 64'(mem_rf_wdata), 0);
        check("rst_stall", 64'(mem_ld_stall), 0);
        check("rst_allowin", 64'(mem_allowin), 1);
        check("rst_cnt", 64'(u32.discard_cnt_q), 0);
        step();
        resetn = 1'b1;

        // 1: LD_B at byte 3, response after 3 stall cycles
        issue(0, 32'h100, 3'd0, 64'h1003, 1, 1, 5'd5, 1, 1, 64'hFFFF_FF80);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_stall", 64'(mem_ld_stall), 1);
            step();
        end
        data_ok = 1; rdata = 32'h80FF_1234;
        @(negedge clk);
        check("t1_stall_released", 64'(mem_ld_stall), 0);
        step();
        data_ok = 0;

        // 2: LD_HU at byte 2, WB blocked so the response is buffered
        issue(0, 32'h104, 3'd5, 64'h2002, 1, 1, 5'd6, 1, 1, 64'h0000_8001);
        wb_allowin = 0; data_ok = 1; rdata = 32'h8001_0000;
        @(negedge clk);
        check("t2_live_wdata", 64'(mem_rf_wdata), 64'h8001);
        step();
        data_ok = 0; rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t2_buf_v", 64'(u32.buf_v_q), 1);
            check("t2_held_wdata", 64'(mem_rf_wdata), 64'h8001);
            step();
        end
        wb_allowin = 1;
        step();

        // 3: flush with MEM waiting and EX request in flight, two stale responses dropped
        issue(0, 32'h200, 3'd2, 64'h3000, 1, 1, 5'd7, 1, 0, 0);
        ex_mem_valid = 1; ex_req_issued = 1; ex_pc = 32'h204; wb_flush = 1;
        step();
        wb_flush = 0; ex_mem_valid = 0;
        @(negedge clk);
        check("t3_cnt2", 64'(u32.discard_cnt_q), 2);
        check("t3_flushed", 64'(mem_wb_valid), 0);
        issue(0, 32'h208, 3'd2, 64'h4000, 1, 1, 5'd9, 1, 1, 64'h1357_2468);
        data_ok = 1; rdata = 32'hBAD0_0001;
        @(negedge clk);
        check("t3_drop1", 64'(mem_wb_valid), 0);
        check("t3_drop1_stall", 64'(mem_ld_stall), 1);
        step();
        rdata = 32'hBAD0_0002;
        @(negedge clk);
        check("t3_cnt1", 64'(u32.discard_cnt_q), 1);
        check("t3_drop2", 64'(mem_wb_valid), 0);
        step();
        rdata = 32'h1357_2468;
        @(negedge clk);
        check("t3_cnt0", 64'(u32.discard_cnt_q), 0);
        step();
        data_ok = 0;

        // 4: flush coinciding with MEM's own response
        issue(0, 32'h300, 3'd2, 64'h5000, 1, 1, 5'd4, 1, 0, 0);
        data_ok = 1; rdata = 32'h0BAD_0BAD; wb_flush = 1;
        step();
        data_ok = 0; wb_flush = 0;
        @(negedge clk);
        check("t4_cnt", 64'(u32.discard_cnt_q), 0);
        check("t4_mem_valid", 64'(u32.mem_valid_q), 0);

        // Store waits for data_ok and writes nothing
        issue(0, 32'h380, 3'd2, 64'h6000, 0, 0, 5'd0, 1, 1, 64'h6000);
        @(negedge clk);
        check("st_wait", 64'(mem_wb_valid), 0);
        check("st_no_ldstall", 64'(mem_ld_stall), 0);
        step();
        data_ok = 1; rdata = 32'h0;
        step();
        data_ok = 0;

        // 6: asynchronous reset while waiting with one stale response owed
        issue(0, 32'h400, 3'd2, 64'h7000, 1, 1, 5'd2, 1, 0, 0);
        wb_flush = 1;
        step();
        wb_flush = 0;
        issue(0, 32'h404, 3'd2, 64'h7004, 1, 1, 5'd3, 1, 0, 0);
        @(negedge clk);
        check("t6_pre_cnt", 64'(u32.discard_cnt_q), 1);
        check("t6_pre_stall", 64'(mem_ld_stall), 1);
        #1 resetn = 0;
        #1;
        check("t6_cnt", 64'(u32.discard_cnt_q), 0);
        check("t6_pc", 64'(mem_pc), 0);
        check("t6_rf_we", 64'(mem_rf_we), 0);
        check("t6_stall", 64'(mem_ld_stall), 0);
        check("t6_wb_valid", 64'(mem_wb_valid), 0);
        check("t6_wdata", 64'(mem_rf_wdata), 0);
        step();
        resetn = 1;
        ex_except = '0; ex_except[0] = 1'b1;
        issue(0, 32'h500, 3'd2, 64'h55AA, 0, 1, 5'd3, 0, 1, 64'h55AA);
        ex_except = '0;
        @(negedge clk);
        check("t6_exc", 64'(mem_exc), 1);
        step();

        // 5: DW=64 alignment
        issue(1, 32'h600, 3'd2, 64'h1004, 1, 1, 5'd10, 1, 1, 64'hFFFF_FFFF_8765_4321);
        data_ok64 = 1; rdata64 = 64'h8765_4321_0000_0000;
        step();
        data_ok64 = 0;
        issue(1, 32'h604, 3'd3, 64'h2000, 1, 1, 5'd11, 1, 1, 64'h0123_4567_89AB_CDEF);
        data_ok64 = 1; rdata64 = 64'h0123_4567_89AB_CDEF;
        step();
        data_ok64 = 0;
        issue(1, 32'h608, 3'd4, 64'h3005, 1, 1, 5'd12, 1, 1, 64'h43);
        data_ok64 = 1; rdata64 = 64'h8765_4321_0000_0000;
        step();
        data_ok64 = 0;
        issue(1, 32'h60C, 3'd1, 64'h3006, 1, 1, 5'd13, 1, 1, 64'hFFFF_FFFF_FFFF_8765);
        data_ok64 = 1; rdata64 = 64'h8765_4321_0000_0000;
        step();
        data_ok64 = 0;
        repeat (3) step();

        check("q32_drained", 64'(q32.size()), 0);
        check("q64_drained", 64'(q64.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
